// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait-state handshake and wait-timeout watchdog.
// Optional ori/bne support is compiled in with `define MC_EXT_INSTR_EN.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       zext,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12,
    BNEEX   = 4'd13,
    HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // The counter only has to hold 0..MEM_TIMEOUT-1; the final wait cycle trips the fault.
  localparam int CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  state_t          state;
  state_t          state_next;
  state_t          cur;
  logic [CW-1:0]   wait_cnt;
  logic            waiting;
  logic            timeout;

  assign waiting = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == LIMIT_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (timeout) begin
        state   <= HALT;
        mem_err <= 1'b1;
      end else begin
        state <= state_next;
      end
      if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;
    end
  end

  // While reset is held the outputs decode as FETCH, whatever the register holds.
  assign cur = reset ? state : FETCH;

  always_comb begin
    state_next = state;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    zext       = 1'b0;
    alucontrol = ALU_AND;
    illegal_op = 1'b0;

    case (state)
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
`ifdef MC_EXT_INSTR_EN
          OP_ORI:       state_next = ORIEX;
          OP_BNE:       state_next = BNEEX;
`endif
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_next = MEMWB;
      MEMWB:   state_next = FETCH;
      MEMWR:   if (mem_ready) state_next = FETCH;
      RTYPEEX: state_next = RTYPEWB;
      RTYPEWB: state_next = FETCH;
      BEQEX:   state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JEX:     state_next = FETCH;
`ifdef MC_EXT_INSTR_EN
      ORIEX:   state_next = ADDIWB;
      BNEEX:   state_next = FETCH;
`endif
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase

    case (cur)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = mem_ready;
        pcen       = mem_ready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_EXT_INSTR_EN
          OP_ORI, OP_BNE:                                illegal_op = 1'b0;
`endif
          default:                                       illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      // The store strobe stays up for the whole access, including wait cycles.
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
`ifdef MC_EXT_INSTR_EN
      ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        zext       = 1'b1;
        alucontrol = ALU_OR;
      end
      BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ~zero;
      end
`endif
      default: begin
        pcen = 1'b0;
      end
    endcase

    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule
